// File: rtl/blur_pkg.sv
// rtl/blur_pkg.sv - shared pixel types and default raster geometry for the blur pipeline
package blur_pkg;

  localparam int PIXEL_W    = 8;
  localparam int IMG_WIDTH  = 64;
  localparam int IMG_HEIGHT = 64;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t pixel;
    logic   sof;
    logic   eol;
    logic   eof;
  } tagged_pix_t;

endpackage

// File: rtl/blur_sync_fifo.sv
// rtl/blur_sync_fifo.sv - first-word-fall-through sync FIFO with a registered head and occupancy count
module blur_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      level_after_pop;
  logic             do_push;
  logic             do_pop;

  assign empty           = (level == '0);
  assign full            = (level == (AW+1)'(DEPTH));
  assign do_pop          = pop && !empty;
  assign do_push         = push && (!full || do_pop);
  assign rd_next         = rd_ptr + AW'(1);
  assign level_after_pop = level - (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // dout is the registered head: reloaded from storage on pop, or straight from din into an empty FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_next;
      level <= level_after_pop + (AW+1)'(do_push);
      if (level_after_pop == '0) begin
        if (do_push) dout <= din;
      end else if (do_pop) begin
        dout <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/blur_frame_collector.sv
// rtl/blur_frame_collector.sv - tags blurred raster pixels with sof/eol/eof and buffers them for a ready/valid consumer
// Optional per-frame checksum on frame_sum is built only when COLLECTOR_CHECKSUM_EN is defined.
module blur_frame_collector #(
  parameter int IMG_WIDTH  = blur_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = blur_pkg::IMG_HEIGHT,
  parameter int FIFO_DEPTH = 16,
  parameter int PIXEL_W    = blur_pkg::PIXEL_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PIXEL_W-1:0]            pixel_in,
  input  logic                          pixel_vld,
  output logic [PIXEL_W-1:0]            m_data,
  output logic                          m_sof,
  output logic                          m_eol,
  output logic                          m_eof,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          overflow,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [PIXEL_W+15:0]           frame_sum
);

  import blur_pkg::*;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int SW = PIXEL_W + 16;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef struct packed {
    logic [PIXEL_W-1:0] pixel;
    logic               sof;
    logic               eol;
    logic               eof;
  } entry_t;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  entry_t        wr_entry;
  entry_t        rd_entry;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign wr_entry.pixel = pixel_in;
  assign wr_entry.sof   = (col == '0) && (row == '0);
  assign wr_entry.eol   = (col == COL_LAST);
  assign wr_entry.eof   = (col == COL_LAST) && (row == ROW_LAST);

  assign m_valid = !empty;
  assign pop     = m_valid && m_ready;
  assign push    = pixel_vld && (!full || pop);

  // Counters follow every source pixel, dropped or not, so tags stay aligned with the raster
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pixel_vld) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  blur_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (rd_entry),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign m_data = rd_entry.pixel;
  assign m_sof  = rd_entry.sof;
  assign m_eol  = rd_entry.eol;
  assign m_eof  = rd_entry.eof;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      overflow   <= overflow | (pixel_vld && full && !pop);
      frame_done <= pop && rd_entry.eof;
    end
  end

`ifdef COLLECTOR_CHECKSUM_EN
  logic [SW-1:0] acc;
  logic [SW-1:0] acc_next;
  logic [SW-1:0] sum_q;

  assign acc_next = rd_entry.sof ? SW'(rd_entry.pixel) : acc + SW'(rd_entry.pixel);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      sum_q <= '0;
    end else if (pop) begin
      acc <= acc_next;
      if (rd_entry.eof) sum_q <= acc_next;
    end
  end

  assign frame_sum = sum_q;
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_blur_frame_collector.sv
// tb/tb_blur_frame_collector.sv - randomized and directed bench for blur_frame_collector against a queue model
module tb_blur_frame_collector;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int D  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic          pixel_vld = 1'b0;
  logic [PW-1:0] m_data;
  logic          m_sof, m_eol, m_eof, m_valid;
  logic          m_ready = 1'b0;
  logic          overflow, frame_done;
  logic [2:0]    fifo_level;
  logic [PW+15:0] frame_sum;

  blur_frame_collector #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D), .PIXEL_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_vld(pixel_vld),
    .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .m_valid(m_valid), .m_ready(m_ready), .overflow(overflow),
    .frame_done(frame_done), .fifo_level(fifo_level), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] px;
    logic       sof;
    logic       eol;
    logic       eof;
  } ent_t;

  ent_t        q[$];
  ent_t        log_q[$];
  int          pcount;
  logic        exp_ovf;
  logic        exp_done;
  logic [23:0] exp_sum;
  logic [23:0] acc;
  bit          model_on = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          done_count = 0;
  logic [23:0] sum_at_done = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is W*H consecutive source pixels; the FIFO is a queue capped at D
  function automatic void model_step(input logic vld, input logic [7:0] px, input logic rdy);
    ent_t e;
    int   pos;
    bit   was_full;
    bit   popped;
    was_full = (q.size() == D);
    popped   = (q.size() > 0) && rdy;
    exp_done = 1'b0;
    if (popped) begin
      e = q.pop_front();
      acc = e.sof ? 24'(e.px) : acc + 24'(e.px);
      if (e.eof) begin
        exp_done = 1'b1;
`ifdef COLLECTOR_CHECKSUM_EN
        exp_sum = acc;
`endif
      end
    end
    if (vld) begin
      pos   = pcount % (W * H);
      e.px  = px;
      e.sof = (pos == 0);
      e.eol = ((pos % W) == W - 1);
      e.eof = (pos == W * H - 1);
      if (!was_full || popped) q.push_back(e);
      else exp_ovf = 1'b1;
      pcount++;
    end
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
      chk("fifo_level", 32'(fifo_level), 32'(q.size()));
      if (q.size() != 0) begin
        chk("m_data", 32'(m_data), 32'(q[0].px));
        chk("m_sof", 32'(m_sof), 32'(q[0].sof));
        chk("m_eol", 32'(m_eol), 32'(q[0].eol));
        chk("m_eof", 32'(m_eof), 32'(q[0].eof));
      end
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("frame_done", 32'(frame_done), 32'(exp_done));
      chk("frame_sum", 32'(frame_sum), 32'(exp_sum));
      if (frame_done) begin
        done_count++;
        sum_at_done = frame_sum;
      end
    end
  end

  task automatic cycle(input logic vld, input logic [7:0] px, input logic rdy);
    ent_t e;
    pixel_vld = vld;
    pixel_in  = px;
    m_ready   = rdy;
    if (m_valid && rdy) begin
      e.px = m_data; e.sof = m_sof; e.eol = m_eol; e.eof = m_eof;
      log_q.push_back(e);
    end
    @(posedge clk);
    model_step(vld, px, rdy);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic vld);
    rst_n     = 1'b0;
    pixel_vld = vld;
    pixel_in  = 8'hee;
    m_ready   = 1'b1;
    @(posedge clk);
    q.delete();
    pcount   = 0;
    exp_ovf  = 1'b0;
    exp_done = 1'b0;
    exp_sum  = '0;
    acc      = '0;
    model_on = 1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic chk_log_seq(input string name, input int n, input logic [7:0] base);
    chk({name, "_count"}, 32'(log_q.size()), 32'(n));
    if (log_q.size() >= n)
      for (int i = 0; i < n; i++) chk({name, "_data"}, 32'(log_q[i].px), 32'(base + 8'(i)));
  endtask

  initial begin
    int dc0;

    // reset values and a plain frame
    do_reset(1'b0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    dc0 = done_count;
    log_q.delete();
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b1);
    drain(3);
    chk_log_seq("f1", 8, 8'h10);
    if (log_q.size() >= 8)
      for (int i = 0; i < 8; i++) begin
        chk("f1_sof", 32'(log_q[i].sof), 32'(i == 0));
        chk("f1_eol", 32'(log_q[i].eol), 32'(i == 3 || i == 7));
        chk("f1_eof", 32'(log_q[i].eof), 32'(i == 7));
      end
    chk("f1_done_pulses", 32'(done_count - dc0), 32'd1);
    chk("f1_overflow", 32'(overflow), 32'd0);

    // stall until full, two pixels dropped
    log_q.delete();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    drain(6);
    chk_log_seq("ovf", 4, 8'h20);
    log_q.delete();
    cycle(1'b1, 8'h26, 1'b1);
    cycle(1'b1, 8'h27, 1'b1);
    cycle(1'b1, 8'h28, 1'b1);
    drain(3);
    chk("next_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("next_data", 32'(log_q[2].px), 32'h28);
      chk("next_sof", 32'(log_q[2].sof), 32'd1);
    end

    // push and pop together at full
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0);
    cycle(1'b1, 8'h44, 1'b1);
    chk("full_pp_level", 32'(fifo_level), 32'd4);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    drain(5);

    // toggling ready with a back-to-back frame
    log_q.delete();
    for (int j = 0; j < 12; j++) begin
      if (j < 6 || j == 8 || j == 10) cycle(1'b1, 8'h50 + 8'(log_q.size() + q.size()), (j % 2) == 0);
      else cycle(1'b0, 8'h00, (j % 2) == 0);
    end
    for (int j = 0; j < 8; j++) cycle(1'b0, 8'h00, (j % 2) == 0);
    drain(2);
    chk_log_seq("toggle", 8, 8'h50);
    chk("toggle_ovf", 32'(overflow), 32'd0);

    // reset mid-frame with buffered data
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0);
    do_reset(1'b1);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_valid", 32'(m_valid), 32'd0);
    chk("midrst_data", 32'(m_data), 32'd0);
    log_q.delete();
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b1);
    drain(3);
    chk_log_seq("midrst", 8, 8'h30);
    if (log_q.size() >= 1) chk("midrst_sof", 32'(log_q[0].sof), 32'd1);

    // checksum frame
    do_reset(1'b0);
    dc0 = done_count;
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h01 + 8'(i), 1'b1);
    drain(3);
    chk("sum_done_pulses", 32'(done_count - dc0), 32'd1);
`ifdef COLLECTOR_CHECKSUM_EN
    chk("sum_value", 32'(sum_at_done), 32'h24);
`else
    chk("sum_value", 32'(sum_at_done), 32'h0);
`endif

    // randomized traffic with one reset in the middle
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset(1'($urandom % 2));
      else cycle($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom % 2));
    end
    drain(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
